// File: rtl/lifo_rev_pkg.sv
// Shared types and defaults for the LIFO frame reverser.
package lifo_rev_pkg;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;
  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/lifo_rev_stack.sv
// Push/pop stack: storage array plus occupancy pointer. Top is always mem[count-1].
module lifo_rev_stack
  import lifo_rev_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] top,
  output logic [PTR_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     wr_idx, rd_idx;

  assign full   = (cnt_q == DEPTH_P);
  assign empty  = (cnt_q == '0);
  assign count  = cnt_q;
  assign wr_idx = AW'(cnt_q);
  assign rd_idx = AW'(cnt_q - ONE);
  assign top    = mem_q[rd_idx];

  // Occupancy update; guards keep count inside 0..DEPTH even on a stray request.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !full)       cnt_d = cnt_q + ONE;
    else if (pop && !empty)  cnt_d = cnt_q - ONE;
  end

  // Occupancy register; reset empties the stack in one cycle.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Storage write at the current fill level; contents are never cleared.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_idx] <= wdata;
  end

endmodule

// File: rtl/lifo_frame_reverser.sv
// Frame reverser: pushes an incoming byte frame, then pops it out in reverse.
// Frames longer than the stack are truncated; the excess is discarded until s_last.
// Optional build macro LIFO_REV_DROP_CNT_EN adds a saturating drop_cnt output.
module lifo_frame_reverser
  import lifo_rev_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [PTR_W-1:0]  count,
  output logic              busy
`ifdef LIFO_REV_DROP_CNT_EN
  , output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);
  localparam logic [PTR_W-1:0] DEPTH_M1 = PTR_W'(DEPTH - 1);

  state_t state_q, state_d;
  logic   trunc_q, trunc_d;
  logic   s_acc, m_acc, push, pop, full, empty;

  assign s_acc = s_valid && s_ready;
  assign m_acc = m_valid && m_ready;
  assign push  = s_acc && (state_q == ST_FILL);
  assign pop   = m_acc;

  lifo_rev_stack #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(s_data),
    .top  (m_data),
    .count(count),
    .full (full),
    .empty(empty)
  );

  // State and truncation flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trunc_q <= trunc_d;
    end
  end

  // Next state: fill ends on s_last or when the push fills the stack (truncation).
  always_comb begin
    state_d = state_q;
    trunc_d = trunc_q;
    case (state_q)
      ST_FILL: begin
        if (s_acc) begin
          if (s_last) begin
            state_d = ST_DRAIN;
            trunc_d = 1'b0;
          end else if (count == DEPTH_M1) begin
            state_d = ST_DRAIN;
            trunc_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (m_acc && count == ONE) state_d = trunc_q ? ST_DISCARD : ST_FILL;
      end
      ST_DISCARD: begin
        if (s_acc && s_last) begin
          state_d = ST_FILL;
          trunc_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_FILL;
        trunc_d = 1'b0;
      end
    endcase
  end

  // Handshake outputs decoded from state and occupancy only (no m_ready path to m_valid).
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    case (state_q)
      ST_FILL:    s_ready = !full;
      ST_DRAIN: begin
        m_valid = !empty;
        m_last  = (count == ONE);
      end
      ST_DISCARD: s_ready = 1'b1;
      default:    s_ready = 1'b0;
    endcase
    busy = !((state_q == ST_FILL) && empty);
  end

`ifdef LIFO_REV_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // Count bytes thrown away after a truncated frame; saturates, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                                                       drop_cnt_q <= '0;
    else if (s_acc && state_q == ST_DISCARD && drop_cnt_q != '1)   drop_cnt_q <= drop_cnt_q + 1'b1;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_lifo_frame_reverser.sv
// Directed bench for lifo_frame_reverser with a reversed-frame scoreboard.
module tb_lifo_frame_reverser;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready = 1'b0;
  logic [3:0] count;
  logic       busy;
`ifdef LIFO_REV_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int         checks = 0;
  int         errors = 0;
  int         exp_drop = 0;
  beat_t      sbq[$];
  logic [7:0] frm[$];

  lifo_frame_reverser #(.DATA_W(8), .DEPTH(DEPTH), .PTR_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_last (s_last),
    .s_ready(s_ready),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_last (m_last),
    .m_ready(m_ready),
    .count  (count),
    .busy   (busy)
`ifdef LIFO_REV_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake and checks hold stability.
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = '0;
  logic       hold_l = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && m_valid) begin
        chk("hold_data", 32'(m_data), 32'(hold_d));
        chk("hold_last", 32'(m_last), 32'(hold_l));
      end
      if (m_valid && m_ready) begin
        if (sbq.size() == 0) chk("extra_beat", 32'(sbq.size()), 32'(1));
        else begin
          beat_t b;
          b = sbq.pop_front();
          chk("m_data", 32'(m_data), 32'(b.d));
          chk("m_last", 32'(m_last), 32'(b.l));
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end
  end

  // Present one byte and hold it until accepted; returns at posedge+1 of the accept edge.
  task automatic send_byte(input logic [7:0] d, input logic lst);
    int tmo;
    tmo = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = lst;
    @(negedge clk);
    while (!s_ready && tmo < 200) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 200) chk("s_ready_tmo", 32'(tmo), 32'(0));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Send frm; the reversed (possibly truncated) frame is queued as soon as fill ends.
  task automatic send_frame();
    logic [7:0] stk[$];
    bit filling;
    bit lst;
    filling = 1'b1;
    for (int i = 0; i < frm.size(); i++) begin
      lst = (i == frm.size() - 1);
      send_byte(frm[i], lst);
      if (filling) begin
        stk.push_back(frm[i]);
        if (lst || stk.size() == DEPTH) begin
          for (int j = stk.size() - 1; j >= 0; j--) sbq.push_back('{d: stk[j], l: (j == 0)});
          filling = 1'b0;
        end
      end else begin
        exp_drop++;
      end
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((sbq.size() != 0 || m_valid) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("sb_empty", 32'(sbq.size()), 32'(0));
  endtask

  logic rp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int   cnt_exp;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_s_ready", 32'(s_ready), 32'(1));
    chk("rst_m_valid", 32'(m_valid), 32'(0));
    chk("rst_m_last",  32'(m_last),  32'(0));
    chk("rst_busy",    32'(busy),    32'(0));
    chk("rst_count",   32'(count),   32'(0));
`ifdef LIFO_REV_DROP_CNT_EN
    chk("rst_drop", 32'(drop_cnt), 32'(0));
`endif

    // 1: three-byte frame, reversed, s_ready low while draining
    m_ready = 1'b1;
    frm = '{8'h11, 8'h22, 8'h33};
    send_frame();
    chk("t1_m_valid", 32'(m_valid), 32'(1));
    chk("t1_s_ready", 32'(s_ready), 32'(0));
    chk("t1_busy",    32'(busy),    32'(1));
    wait_done();

    // 2: single-byte frame, valid the cycle after s_last
    frm = '{8'hA5};
    send_frame();
    chk("t2_m_valid", 32'(m_valid), 32'(1));
    chk("t2_m_last",  32'(m_last),  32'(1));
    chk("t2_count",   32'(count),   32'(1));
    wait_done();
    chk("t2_s_ready", 32'(s_ready), 32'(1));
    chk("t2_busy",    32'(busy),    32'(0));

    // 3: ten-byte frame truncated at DEPTH, excess dropped
    frm.delete();
    for (int i = 0; i < 10; i++) frm.push_back(8'(i));
    send_frame();
    wait_done();
    chk("t3_s_ready", 32'(s_ready), 32'(1));
    chk("t3_busy",    32'(busy),    32'(0));
    chk("t3_exp_drop", 32'(exp_drop), 32'(2));
`ifdef LIFO_REV_DROP_CNT_EN
    chk("t3_drop", 32'(drop_cnt), 32'(exp_drop));
`endif

    // 4: exactly DEPTH bytes with s_last on the last: normal end, no discard
    frm.delete();
    for (int i = 0; i < DEPTH; i++) frm.push_back(8'h40 + 8'(i));
    send_frame();
    chk("t4_full_cnt", 32'(count), 32'(DEPTH));
    wait_done();
    chk("t4_busy",    32'(busy),    32'(0));
    chk("t4_s_ready", 32'(s_ready), 32'(1));
`ifdef LIFO_REV_DROP_CNT_EN
    chk("t4_drop", 32'(drop_cnt), 32'(exp_drop));
`endif

    // 5: consumer back-pressure during a four-byte drain
    m_ready = 1'b0;
    frm = '{8'h61, 8'h62, 8'h63, 8'h64};
    send_frame();
    cnt_exp = 4;
    for (int k = 0; k < 6; k++) begin
      m_ready = rp[k];
      @(negedge clk);
      chk("t5_count", 32'(count), 32'(cnt_exp));
      if (rp[k]) cnt_exp--;
      @(posedge clk);
      #1;
    end
    chk("t5_count_end", 32'(count), 32'(cnt_exp));
    m_ready = 1'b1;
    wait_done();

    // 6: reset mid-drain discards held data, next frame unaffected
    m_ready = 1'b0;
    frm = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    send_frame();
    m_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("t6_pre_cnt", 32'(count), 32'(3));
    m_ready = 1'b0;
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_m_valid", 32'(m_valid), 32'(0));
    chk("t6_count",   32'(count),   32'(0));
    chk("t6_s_ready", 32'(s_ready), 32'(1));
`ifdef LIFO_REV_DROP_CNT_EN
    chk("t6_drop", 32'(drop_cnt), 32'(0));
`endif
    m_ready = 1'b1;
    frm = '{8'hC1, 8'hC2};
    send_frame();
    wait_done();
    chk("t6_busy", 32'(busy), 32'(0));

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
